rom_loader: RTL
===============

# rom_loader

Byte-stream program loader that sits directly upstream of the SoC's instruction ROM. It replaces the bench-only `$readmemh` preload with a synthesizable path. It accepts a framed byte stream (length header, little-endian instruction words, checksum) over a valid/ready interface and writes each assembled word into the ROM write port. It holds the core in reset until the image is complete and its checksum has been verified.

## Interface
- `ADDR_W`, 12, ROM word-address width; capacity is 2^ADDR_W words.
- `TIMEOUT_CYC`, 1_000_000, maximum idle cycles between accepted bytes once a frame has started.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `byte_valid_i`  in  1  upstream byte is valid.
- `byte_data_i`  in  8  upstream byte.
- `byte_ready_o`  out  1  loader can accept a byte.
- `rom_we_o`  out  1  one-cycle ROM write strobe.
- `rom_waddr_o`  out  ADDR_W  ROM word address.
- `rom_wdata_o`  out  32  ROM write data.
- `core_rst_n_o`  out  1  active-low reset to the core; low until a good load completes.
- `busy_o`  out  1  a frame is in progress (header byte 0 has been accepted).
- `done_o`  out  1  load complete and checksum good; sticky.
- `err_o`  out  1  load failed; sticky.

## Operation
- A byte transfer is a rising edge with `byte_valid_i && byte_ready_o`.
- Frame format:
  - 2 bytes: word count N, LSB first.
  - 4·N bytes: payload words, each LSB first.
  - 1 byte: checksum, equal to the sum of all payload bytes mod 256.
  - The header bytes are not included in the checksum.
- States and transitions:
  - LEN0 → LEN1 on byte.
  - LEN1 → DATA on byte if 0 < N ≤ 2^ADDR_W.
  - LEN1 → CSUM on byte if N = 0.
  - LEN1 → ERR on byte if N > 2^ADDR_W.
  - DATA → CSUM after the 4th byte of word N−1.
  - CSUM → DONE if the received byte equals the running sum; otherwise CSUM → ERR.
  - DONE and ERR are terminal. Only `rst_n` low exits them, back to LEN0.
- Word assembly:
  - A 2-bit byte-lane counter places each byte into lane `lane·8 +: 8`.
  - On lane 3 the word is complete and is written to address `widx`. `widx` then increments.
  - `widx` is ADDR_W+1 bits wide, so N = 2^ADDR_W does not wrap.
- The running checksum is 8 bits and wraps mod 256.
- Timeout:
  - Applies in LEN1, DATA and CSUM.
  - Counts idle cycles since the last accepted byte. Reaching TIMEOUT_CYC → ERR.
  - Not active in LEN0, so the loader waits indefinitely for a frame to start.
- `byte_ready_o` = 1 in LEN0, LEN1, DATA and CSUM. It is 0 in DONE and ERR, and 0 while `rst_n` is low.
- Reset values: `byte_ready_o`=0, `rom_we_o`=0, `rom_waddr_o`=0, `rom_wdata_o`=0, `core_rst_n_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0. State=LEN0; all counters and the checksum = 0.
- `rst_n` asserted mid-frame discards the partial frame. Words already written stay in the ROM. `core_rst_n_o` stays 0.
- The ROM is not cleared on ERR. The core never leaves reset after an error.

## Timing
- The loader accepts at most 1 byte per cycle. Full throughput applies with `byte_valid_i` held high.
- `rom_we_o` pulses exactly 1 cycle, in the cycle after the edge that accepted lane 3. Address and data are registered and valid in that same cycle.
- `core_rst_n_o` and `done_o` rise in the cycle after a good checksum byte is accepted. `err_o` rises in the cycle after any error condition.
- `busy_o` rises in the cycle after the LEN0 byte is accepted and falls on entry to DONE or ERR.
- Minimum load latency: 2+4N+1 byte-cycles, plus 1 cycle to release `core_rst_n_o`.
- A byte accepted on the same edge as the timeout expiry takes priority; the timeout is discarded.

## Structure
- Package `loader_pkg` holds:
  - the state enum (LEN0, LEN1, DATA, CSUM, DONE, ERR);
  - `HDR_BYTES`=2 and `CSUM_BYTES`=1.
- Sub-module `loader_word_asm`: byte-lane counter, 32-bit shift/insert register and word-complete strobe. Its output feeds the ROM write register in `rom_loader`.
- Top-level integration: `soc` takes `core_rst_n_o` as the core reset and muxes the ROM write port. The bench drives the byte stream from the existing instruction `.txt` images.

## Test plan
- N=2, words 0x00000093 and 0x00108113, correct checksum → two `rom_we_o` pulses at addresses 0 and 1 with those data; `done_o`=1; `core_rst_n_o` rises 1 cycle after the checksum byte.
- N=1, word 0xDEADBEEF, checksum off by one → `err_o`=1; `core_rst_n_o` stays 0; `byte_ready_o`=0 thereafter.
- N=0, checksum byte 0x00 → `done_o`=1; no `rom_we_o` pulse.
- N=2^ADDR_W+1 header → ERR on the LEN1 byte; zero writes.
- Stall of TIMEOUT_CYC cycles after the 3rd payload byte → ERR. A stall of TIMEOUT_CYC−1 cycles followed by the byte → normal completion.
- `rst_n` pulsed low after 5 payload bytes, then a full rv32ui-p-addi image loaded → `done_o`=1; the addi test then reports pass (x26=1, x27=1).

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the ROM byte-stream loader.
// The state enum is shared by the top and the bench-visible FSM.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int CSUM_BYTES = 1;

  // DONE and ERR are only left through rst_n.
  function automatic logic is_terminal(input state_t s);
    return (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Assembles little-endian bytes into 32-bit words.
// Raises a strobe on the byte that completes a word.
module loader_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  lane;
  logic [31:0] word_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane   <= '0;
      word_q <= '0;
    end else if (push) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      word_q[{lane, 3'b000} +: 8] <= data;
      lane                        <= lane + 2'd1;
    end
  end

  // The completing byte is merged combinationally so the word is whole on the lane-3 edge.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    word                        = word_q;
    word[{lane, 3'b000} +: 8]   = data;
    word_done                   = push && (lane == 2'd3);
  end

endmodule

// File: rtl/rom_loader.sv
// Framed byte-stream loader for the instruction ROM: length header, payload words,
// checksum. Holds the core in reset until a good image has been written.
module rom_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_waddr_o,
  output logic [31:0]       rom_wdata_o,
  output logic              core_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int          TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] CAP  = 32'd1 << ADDR_W;

  state_t            state;
  logic [7:0]        len_lo;
  logic [15:0]       n_q;
  logic [ADDR_W:0]   widx;
  logic [7:0]        csum;
  logic [TO_W-1:0]   idle;

  logic              fire;
  logic              in_frame;
  logic [15:0]       n_hdr;
  logic              last_word;
  logic              timeout;
  logic [31:0]       asm_word;
  logic              asm_done;

  assign byte_ready_o = rst_n && !is_terminal(state);
  assign fire         = byte_valid_i && byte_ready_o;
  assign in_frame     = state inside {LEN1, DATA, CSUM};
  assign n_hdr        = {byte_data_i, len_lo};
  assign last_word    = (32'(widx) + 32'd1) == 32'(n_q);
  assign timeout      = idle == TO_W'(TIMEOUT_CYC - 1);

  loader_word_asm u_word_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fire && (state == DATA)),
    .data      (byte_data_i),
    .word      (asm_word),
    .word_done (asm_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= LEN0;
      len_lo       <= '0;
      n_q          <= '0;
      widx         <= '0;
      csum         <= '0;
      idle         <= '0;
      rom_we_o     <= 1'b0;
      rom_waddr_o  <= '0;
      rom_wdata_o  <= '0;
      core_rst_n_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      rom_we_o <= 1'b0;
      if (in_frame) idle <= fire ? '0 : idle + TO_W'(1);

      // An accepted byte wins over a timeout expiring on the same edge.
      if (fire) begin
        unique case (state)
          LEN0: begin
            len_lo <= byte_data_i;
            busy_o <= 1'b1;
            state  <= LEN1;
          end
          LEN1: begin
            n_q <= n_hdr;
            if (n_hdr == 16'd0) begin
              state <= CSUM;
            end else if (32'(n_hdr) > CAP) begin
              state  <= ERR;
              err_o  <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            csum <= csum + byte_data_i;
            if (asm_done) begin
              rom_we_o    <= 1'b1;
              rom_waddr_o <= widx[ADDR_W-1:0];
              rom_wdata_o <= asm_word;
              widx        <= widx + (ADDR_W + 1)'(1);
              if (last_word) state <= CSUM;
            end
          end
          CSUM: begin
            busy_o <= 1'b0;
            if (byte_data_i == csum) begin
              state        <= DONE;
              done_o       <= 1'b1;
              core_rst_n_o <= 1'b1;
            end else begin
              state <= ERR;
              err_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (in_frame && timeout) begin
        state  <= ERR;
        err_o  <= 1'b1;
        busy_o <= 1'b0;
      end
    end
  end

endmodule
